// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and core-side signals of fetch_queue
//   master: the fetch_queue side (drives requests and presented instructions)
//   slave : the environment side (core redirect/consume, instruction memory)
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with in-order buffering and redirect flush
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   bus    : fetch_queue_if.master (redirect in, imem request/response, instruction out, fault)
//   FETCH_MISALIGN_FAULT_EN: when defined, a misaligned redirect raises a sticky fetch_fault
//   and blocks fetch until an aligned redirect; otherwise redirect_pc[1:0] is forced to 0.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          n_rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Repeated redirects can stack discards beyond DEPTH, so drop gets headroom.
    localparam int DW = CW + 2;

    logic [PW:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_inflight;
    logic [DW-1:0] r_drop;
    logic [PW-1:0] r_tag_rd, r_tag_wr;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_tag        [DEPTH];

    logic [PW:0]   w_occ;
    logic [CW:0]   w_budget;
    logic          w_issue, w_acc, w_drop_resp, w_pop, w_fault;
    logic [31:0]   w_redir_pc;

    assign w_occ       = r_wr_ptr - r_rd_ptr;
    assign w_budget    = {1'b0, w_occ} + {1'b0, r_inflight};
    assign w_drop_resp = bus.imem_resp_valid & (r_drop != '0);
    // Responses with nothing outstanding are ignored.
    assign w_acc       = bus.imem_resp_valid & (r_drop == '0) & (r_inflight != '0);

    assign bus.imem_req_valid = n_rst & ~bus.redirect_valid & ~w_fault & (w_budget < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = (w_occ != '0) & ~bus.redirect_valid & ~w_fault;
    assign bus.instr          = bus.instr_valid ? r_fifo_instr[r_rd_ptr[PW-1:0]] : '0;
    assign bus.instr_pc       = bus.instr_valid ? r_fifo_pc[r_rd_ptr[PW-1:0]] : '0;
    assign bus.fetch_fault    = w_fault;

    assign w_issue = bus.imem_req_valid & bus.imem_req_ready;
    assign w_pop   = bus.instr_valid & bus.instr_ready;

`ifdef FETCH_MISALIGN_FAULT_EN
    logic r_fault;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_fault <= 1'b0;
        else if (bus.redirect_valid)
            r_fault <= |bus.redirect_pc[1:0];
    end
    assign w_fault    = r_fault;
    assign w_redir_pc = bus.redirect_pc;
`else
    assign w_fault    = 1'b0;
    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            // Everything outstanding becomes a discard, except a response taken this cycle.
            r_rd_ptr   <= r_wr_ptr;
            r_inflight <= '0;
            r_drop     <= r_drop + DW'(r_inflight) - DW'(w_acc) - DW'(w_drop_resp);
            r_tag_rd   <= r_tag_wr;
            r_fetch_pc <= w_redir_pc;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_acc);
            r_drop     <= r_drop - DW'(w_drop_resp);
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag_wr   <= r_tag_wr + PW'(1);
            end
            if (w_acc) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
                r_tag_rd <= r_tag_rd + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue)
            r_tag[r_tag_wr] <= r_fetch_pc;
        if (w_acc & ~bus.redirect_valid) begin
            r_fifo_instr[r_wr_ptr[PW-1:0]] <= bus.imem_resp_data;
            r_fifo_pc[r_wr_ptr[PW-1:0]]    <= r_tag[r_tag_rd];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with an in-order fixed-latency memory model
module tb_fetch_queue;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if bus();
    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    int k = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Records this cycle's handshake, advances one clock, then drives any due response.
    task automatic tick();
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            q_addr.push_back(bus.imem_req_addr);
            q_due.push_back(cyc + k);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ~q_addr[0];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    task automatic rst();
        n_rst = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.instr_ready     = 1'b1;
        q_addr.delete();
        q_due.delete();
        k = 1;
        #1;
        chk("rst_req", bus.imem_req_valid, 0);
        chk("rst_iv", bus.instr_valid, 0);
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int nreq;
        // T1: reset values then streaming at one instruction per cycle
        rst();
        chk("t1_rst_instr", bus.instr, 0);
        chk("t1_rst_pc", bus.instr_pc, 0);
        chk("t1_rst_fault", bus.fetch_fault, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t1_req", bus.imem_req_valid, 1);
            chk("t1_addr", bus.imem_req_addr, 32'(4 * c));
            chk("t1_iv", bus.instr_valid, 32'(c >= 2));
            if (c >= 2) begin
                chk("t1_pc", bus.instr_pc, 32'(4 * (c - 2)));
                chk("t1_instr", bus.instr, ~32'(4 * (c - 2)));
            end
            tick();
        end
        // T2: core stalled, credit limit of 4 requests, then in-order drain
        rst();
        bus.instr_ready = 1'b0;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.imem_req_valid && bus.imem_req_ready) nreq++;
            tick();
        end
        chk("t2_nreq", 32'(nreq), 4);
        #1;
        chk("t2_req_idle", bus.imem_req_valid, 0);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_iv", bus.instr_valid, 1);
            chk("t2_pc", bus.instr_pc, 32'(4 * i));
            chk("t2_instr", bus.instr, ~32'(4 * i));
            tick();
        end
        // T3: k=3, redirect to 0x100 with 3 outstanding (first one returning that cycle)
        rst();
        k = 3;
        for (int c = 0; c < 3; c++) begin
            #1;
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("t3_redir_iv", bus.instr_valid, 0);
        chk("t3_redir_req", bus.imem_req_valid, 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_addr", bus.imem_req_addr, 32'h100);
        chk("t3_req", bus.imem_req_valid, 1);
        for (int c = 4; c < 8; c++) begin
            #1;
            chk("t3_iv_quiet", bus.instr_valid, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_iv", bus.instr_valid, 1);
            chk("t3_pc", bus.instr_pc, 32'h100 + 32'(4 * i));
            tick();
        end
        // T4: redirect coinciding with a response and a ready core
        rst();
        for (int c = 0; c < 5; c++) begin
            #1;
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("t4_resp_present", bus.imem_resp_valid, 1);
        chk("t4_redir_iv", bus.instr_valid, 0);
        chk("t4_redir_req", bus.imem_req_valid, 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_empty", bus.instr_valid, 0);
        chk("t4_addr", bus.imem_req_addr, 32'h40);
        tick();
        #1;
        chk("t4_iv_c7", bus.instr_valid, 0);
        tick();
        #1;
        chk("t4_iv_c8", bus.instr_valid, 1);
        chk("t4_pc", bus.instr_pc, 32'h40);
        tick();
        // T5: asynchronous reset with a half full FIFO
        rst();
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tick();
        end
        #1;
        chk("t5_pre_iv", bus.instr_valid, 1);
        n_rst = 1'b0;
        #1;
        chk("t5_iv", bus.instr_valid, 0);
        chk("t5_req", bus.imem_req_valid, 0);
        rst();
        #1;
        chk("t5_restart_addr", bus.imem_req_addr, 0);
        chk("t5_restart_req", bus.imem_req_valid, 1);
        tick();
        tick();
        #1;
        chk("t5_iv2", bus.instr_valid, 1);
        chk("t5_pc2", bus.instr_pc, 0);
        tick();
        // T6: misaligned redirect to 0x102
        rst();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("t6_fault", bus.fetch_fault, 1);
        chk("t6_req_blk", bus.imem_req_valid, 0);
        tick();
        #1;
        chk("t6_iv_blk", bus.instr_valid, 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_fault_clr", bus.fetch_fault, 0);
        chk("t6_addr200", bus.imem_req_addr, 32'h200);
        chk("t6_req200", bus.imem_req_valid, 1);
`else
        chk("t6_fault", bus.fetch_fault, 0);
        chk("t6_req", bus.imem_req_valid, 1);
        chk("t6_addr", bus.imem_req_addr, 32'h100);
        tick();
        tick();
        #1;
        chk("t6_iv", bus.instr_valid, 1);
        chk("t6_pc", bus.instr_pc, 32'h100);
`endif
        tick();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
